// File: rtl/camera_config_sequencer.sv
// rtl/camera_config_sequencer.sv - OV7670 register-table sequencer driving the SCCB/I2C command FSM
// Optional macro CAMERA_CFG_RETRY_EN enables per-entry resends after a NACK.
module camera_config_sequencer #(
   parameter int MAIN_CLOCK_FREQUENCY = 27_000_000,
   parameter int ROM_ADDR_WIDTH       = 8,
   parameter int MAX_RETRIES          = 3,
   parameter int XFER_TIMEOUT_CYCLES  = 2_700_000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      i2c_init_done,
   input  logic                      i2c_device_rdy,
   input  logic                      i2c_error,
   output logic                      i2c_store_data,
   output logic                      i2c_send_data,
   output logic [7:0]                i2c_data,
   output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
   input  logic [15:0]               rom_data,
   output logic                      busy,
   output logic                      cfg_done,
   output logic                      cfg_error,
   output logic [ROM_ADDR_WIDTH-1:0] err_index
);
   localparam int TICK_CYCLES = MAIN_CLOCK_FREQUENCY / 1000;

   typedef enum logic [3:0] {
      S_IDLE, S_ROM_WAIT, S_DECODE, S_WAIT_RDY1, S_STORE0, S_STORE1, S_STORE_END,
      S_WAIT_RDY2, S_SEND, S_WAIT_BUSY, S_WAIT_DONE, S_NEXT, S_DELAY, S_DONE, S_FAIL
   } state_t;

   state_t      state;
   logic        start_pend;
   logic [15:0] entry;
   logic [31:0] delay_cnt;
   logic [31:0] tmo_cnt;
   logic        tmo_hit;

`ifdef CAMERA_CFG_RETRY_EN
   localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
   logic [RW-1:0] retry_cnt;
`endif

   // One shared watchdog for all four transfer waits; it is cleared whenever a wait is entered.
   assign tmo_hit = (tmo_cnt >= 32'(XFER_TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         start_pend     <= 1'b0;
         entry          <= '0;
         delay_cnt      <= '0;
         tmo_cnt        <= '0;
         i2c_store_data <= 1'b0;
         i2c_send_data  <= 1'b0;
         i2c_data       <= '0;
         rom_addr       <= '0;
         busy           <= 1'b0;
         cfg_done       <= 1'b0;
         cfg_error      <= 1'b0;
         err_index      <= '0;
`ifdef CAMERA_CFG_RETRY_EN
         retry_cnt      <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if ((start || start_pend) && i2c_init_done) begin
                  start_pend <= 1'b0;
                  rom_addr   <= '0;
                  cfg_done   <= 1'b0;
                  cfg_error  <= 1'b0;
                  busy       <= 1'b1;
`ifdef CAMERA_CFG_RETRY_EN
                  retry_cnt  <= '0;
`endif
                  state      <= S_ROM_WAIT;
               end else if (start) begin
                  start_pend <= 1'b1;
               end
            end
            S_ROM_WAIT: state <= S_DECODE;
            S_DECODE: begin
               entry <= rom_data;
               if (rom_data == 16'hFFFF) begin
                  state <= S_DONE;
               end else if (rom_data[15:8] == 8'hFF) begin
                  delay_cnt <= 32'(rom_data[7:0]) * 32'(TICK_CYCLES);
                  state     <= S_DELAY;
               end else begin
                  tmo_cnt <= '0;
                  state   <= S_WAIT_RDY1;
               end
            end
            S_WAIT_RDY1: begin
               if (i2c_device_rdy) begin
                  i2c_store_data <= 1'b1;
                  i2c_data       <= entry[15:8];
                  state          <= S_STORE0;
               end else if (tmo_hit) state <= S_FAIL;
               else tmo_cnt <= tmo_cnt + 32'd1;
            end
            S_STORE0: begin
               i2c_data <= entry[7:0];
               state    <= S_STORE1;
            end
            S_STORE1: begin
               i2c_store_data <= 1'b0;
               state          <= S_STORE_END;
            end
            S_STORE_END: begin
               tmo_cnt <= '0;
               state   <= S_WAIT_RDY2;
            end
            S_WAIT_RDY2: begin
               if (i2c_device_rdy) begin
                  i2c_send_data <= 1'b1;
                  state         <= S_SEND;
               end else if (tmo_hit) state <= S_FAIL;
               else tmo_cnt <= tmo_cnt + 32'd1;
            end
            S_SEND: begin
               i2c_send_data <= 1'b0;
               tmo_cnt       <= '0;
               state         <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (!i2c_device_rdy) begin
                  tmo_cnt <= '0;
                  state   <= S_WAIT_DONE;
               end else if (tmo_hit) state <= S_FAIL;
               else tmo_cnt <= tmo_cnt + 32'd1;
            end
            S_WAIT_DONE: begin
               if (i2c_device_rdy) begin
                  if (!i2c_error) state <= S_NEXT;
`ifdef CAMERA_CFG_RETRY_EN
                  else if (retry_cnt < RW'(MAX_RETRIES)) begin
                     retry_cnt <= retry_cnt + 1'b1;
                     tmo_cnt   <= '0;
                     state     <= S_WAIT_RDY1;
                  end
`endif
                  else state <= S_FAIL;
               end else if (tmo_hit) state <= S_FAIL;
               else tmo_cnt <= tmo_cnt + 32'd1;
            end
            S_NEXT: begin
`ifdef CAMERA_CFG_RETRY_EN
               retry_cnt <= '0;
`endif
               // An unterminated table stops after its last addressable entry.
               if (&rom_addr) state <= S_DONE;
               else begin
                  rom_addr <= rom_addr + 1'b1;
                  state    <= S_ROM_WAIT;
               end
            end
            S_DELAY: begin
               if (delay_cnt <= 32'd1) state <= S_NEXT;
               else delay_cnt <= delay_cnt - 32'd1;
            end
            S_DONE: begin
               cfg_done <= 1'b1;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
            S_FAIL: begin
               cfg_error <= 1'b1;
               err_index <= rom_addr;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_camera_config_sequencer.sv
// tb/tb_camera_config_sequencer.sv - directed self-checking bench for camera_config_sequencer
// Expectations for the NACK cases follow CAMERA_CFG_RETRY_EN.
module tb_camera_config_sequencer;
   localparam int AW  = 8;
   localparam int TMO = 500;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          i2c_init_done = 1'b1;
   logic          i2c_device_rdy;
   logic          i2c_error;
   logic          i2c_store_data;
   logic          i2c_send_data;
   logic [7:0]    i2c_data;
   logic [AW-1:0] rom_addr;
   logic [15:0]   rom_data;
   logic          busy;
   logic          cfg_done;
   logic          cfg_error;
   logic [AW-1:0] err_index;

   logic [15:0] rom [256];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   n_store, n_send, bad_frames, run_len, xfer_left, nacked;
   logic prev_send, this_nack;
   logic hang = 1'b0;
   int   nack_entry = -1;
   int   nack_count = 0;
   logic [7:0] store_log [16];
   int   send_cyc [16];
   int   sends [256];
   int   t0, k;

   camera_config_sequencer #(
      .XFER_TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .i2c_init_done(i2c_init_done),
      .i2c_device_rdy(i2c_device_rdy), .i2c_error(i2c_error),
      .i2c_store_data(i2c_store_data), .i2c_send_data(i2c_send_data), .i2c_data(i2c_data),
      .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .cfg_done(cfg_done),
      .cfg_error(cfg_error), .err_index(err_index)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   // I2C FSM model: 4-cycle transfer after each send, optional NACKs or a hung device.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         n_store = 0; n_send = 0; bad_frames = 0; run_len = 0; xfer_left = 0; nacked = 0;
         prev_send = 1'b0; this_nack = 1'b0; i2c_device_rdy = 1'b1; i2c_error = 1'b0;
         foreach (sends[i]) sends[i] = 0;
      end else begin
         if (i2c_store_data) begin
            if (n_store < 16) store_log[n_store] = i2c_data;
            n_store++;
            run_len++;
            if (i2c_send_data) bad_frames++;
         end else begin
            if (run_len != 0 && run_len != 2) bad_frames++;
            run_len = 0;
         end
         if (i2c_send_data) begin
            if (prev_send) bad_frames++;
            if (n_send < 16) send_cyc[n_send] = cyc;
            n_send++;
            sends[rom_addr]++;
            i2c_device_rdy = 1'b0;
            i2c_error = 1'b0;
            xfer_left = 4;
            this_nack = (int'(rom_addr) == nack_entry) && (nacked < nack_count);
            if (this_nack) nacked++;
         end else if (!i2c_device_rdy && !hang) begin
            xfer_left--;
            if (xfer_left == 0) begin
               i2c_device_rdy = 1'b1;
               i2c_error = this_nack;
            end
         end
         prev_send = i2c_send_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic load(input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] w2, input logic [15:0] w3);
      foreach (rom[i]) rom[i] = 16'hFFFF;
      rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
   endtask

   task automatic wait_end(input int limit);
      int n = 0;
      while (!(cfg_done || cfg_error) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("end_reached", 32'(n < limit), 1);
   endtask

   initial begin
      load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      do_reset();
      check("rst_busy", busy, 0);
      check("rst_done", cfg_done, 0);
      check("rst_error", cfg_error, 0);
      check("rst_store", i2c_store_data, 0);
      check("rst_send", i2c_send_data, 0);
      check("rst_data", i2c_data, 0);
      check("rst_addr", rom_addr, 0);
      check("rst_eidx", err_index, 0);

      // Two writes separated by a 1 ms delay entry.
      load(16'h1280, 16'hFF01, 16'h1101, 16'hFFFF);
      do_reset();
      pulse_start();
      check("t1_busy", busy, 1);
      wait_end(40000);
      @(negedge clk);
      check("t1_done", cfg_done, 1);
      check("t1_busy_end", busy, 0);
      check("t1_error", cfg_error, 0);
      check("t1_sends", n_send, 2);
      check("t1_stores", n_store, 4);
      check("t1_b0", store_log[0], 8'h12);
      check("t1_b1", store_log[1], 8'h80);
      check("t1_b2", store_log[2], 8'h11);
      check("t1_b3", store_log[3], 8'h01);
      check("t1_framing", bad_frames, 0);
      check("t1_gap", 32'((send_cyc[1] - send_cyc[0]) >= 27000 && (send_cyc[1] - send_cyc[0]) < 27100), 1);

      // Entry 1 NACKed twice.
      load(16'h1280, 16'h1344, 16'h1455, 16'hFFFF);
      nack_entry = 1; nack_count = 2;
      do_reset();
      pulse_start();
      wait_end(3000);
      @(negedge clk);
`ifdef CAMERA_CFG_RETRY_EN
      check("t2_sends_e1", sends[1], 3);
      check("t2_sends", n_send, 5);
      check("t2_stores", n_store, 10);
      check("t2_done", cfg_done, 1);
      check("t2_error", cfg_error, 0);
`else
      check("t2_sends_e1", sends[1], 1);
      check("t2_sends", n_send, 2);
      check("t2_error", cfg_error, 1);
      check("t2_eidx", err_index, 1);
      check("t2_done", cfg_done, 0);
`endif
      check("t2_framing", bad_frames, 0);

      // Entry 2 always NACKed.
      nack_entry = 2; nack_count = 255;
      do_reset();
      pulse_start();
      wait_end(3000);
      @(negedge clk);
`ifdef CAMERA_CFG_RETRY_EN
      check("t3_sends_e2", sends[2], 4);
      check("t3_sends", n_send, 6);
`else
      check("t3_sends_e2", sends[2], 1);
      check("t3_sends", n_send, 3);
`endif
      check("t3_error", cfg_error, 1);
      check("t3_eidx", err_index, 2);
      check("t3_done", cfg_done, 0);
      check("t3_busy", busy, 0);

      // Device never returns ready after the send.
      nack_entry = -1; nack_count = 0; hang = 1'b1;
      load(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      do_reset();
      t0 = cyc;
      pulse_start();
      wait_end(3000);
      check("t4_elapsed", 32'((cyc - t0) >= TMO && (cyc - t0) < TMO + 40), 1);
      @(negedge clk);
      check("t4_error", cfg_error, 1);
      check("t4_eidx", err_index, 0);
      check("t4_sends", n_send, 1);
      hang = 1'b0;

      // Fully populated table with no end marker.
      foreach (rom[i]) rom[i] = {8'h20, 8'(i)};
      do_reset();
      pulse_start();
      wait_end(10000);
      @(negedge clk);
      check("t5_sends", n_send, 256);
      check("t5_last", sends[255], 1);
      check("t5_done", cfg_done, 1);

      // Pending start, then reset mid-transfer.
      load(16'h1280, 16'h1344, 16'hFFFF, 16'hFFFF);
      i2c_init_done = 1'b0;
      do_reset();
      pulse_start();
      repeat (20) @(negedge clk);
      check("t6_wait_init", busy, 0);
      i2c_init_done = 1'b1;
      repeat (3) @(negedge clk);
      check("t6_started", busy, 1);
      k = 0;
      while (i2c_device_rdy && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("t6_midxfer", 32'(k < 200), 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_rst_outs", {busy, cfg_done, cfg_error, i2c_store_data, i2c_send_data,
                            i2c_data, rom_addr, err_index}, 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("t6_idle", busy, 0);
      i2c_init_done = 1'b0;
      pulse_start();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      i2c_init_done = 1'b1;
      repeat (10) @(negedge clk);
      check("t6_pend_clr", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/camera_config_sequencer.md
# camera_config_sequencer

Sequences the OV7670 register initialisation over the SCCB/I2C command FSM. Walks a register table ROM of `{reg_addr, value}` words and loads each entry into the I2C FSM byte buffer with `store_data`. It then issues `send_data`, waits for completion, checks the slave ACK and inserts millisecond delays where the table requests them. It sits between the top-level camera bring-up logic and `i2c_control_fsm`, and is the only driver of that FSM's command inputs.

## Interface
- `MAIN_CLOCK_FREQUENCY`, default 27_000_000: clk frequency in Hz; sets the 1 ms tick.
- `ROM_ADDR_WIDTH`, default 8: table address width.
- `MAX_RETRIES`, default 3: resend attempts per entry after a NACK.
- `XFER_TIMEOUT_CYCLES`, default 2_700_000: cycle limit per transfer wait (100 ms).
- `clk` input 1: system clock.
- `rst_n` input 1: **reset is synchronous and active-low**. The design has one clock, `clk`.
- `start` input 1: one-cycle pulse that (re)runs the whole table.
- `i2c_init_done` input 1: `init_done` from the I2C FSM.
- `i2c_device_rdy` input 1: `device_rdy` from the I2C FSM.
- `i2c_error` input 1: `error_o` from the I2C FSM (NACK on the last transfer).
- `i2c_store_data` output 1: to `store_data`.
- `i2c_send_data` output 1: to `send_data`.
- `i2c_data` output 8: to `data_in`.
- `rom_addr` output ROM_ADDR_WIDTH: table address.
- `rom_data` input 16: table word, `{reg_addr[15:8], value[7:0]}`; valid 1 cycle after `rom_addr`.
- `busy` output 1: a sequence is running.
- `cfg_done` output 1: sticky; the table completed without a fatal error.
- `cfg_error` output 1: sticky; the sequence aborted.
- `err_index` output ROM_ADDR_WIDTH: table index of the failing entry.

## Operation
- All outputs are registered. Every output resets to 0.
- Table word decode:
  - `16'hFFFF`: end of table.
  - `reg_addr == 8'hFF` with any other value: delay of `value` ms; `value` 0 gives a 1-cycle delay.
  - Anything else: write `value` to `reg_addr`.
- States and transitions:
  - **IDLE**: wait for `start` AND `i2c_init_done`. A `start` arriving before `i2c_init_done` is latched as pending. On entry to a run: `rom_addr`←0, `cfg_done`/`cfg_error`←0, `busy`←1.
  - **ROM_WAIT**: one cycle.
  - **DECODE**: end → DONE; delay → DELAY; otherwise → WAIT_RDY1.
  - **WAIT_RDY1**: wait `i2c_device_rdy`=1.
  - **STORE0**: `i2c_store_data`=1, `i2c_data`=reg_addr.
  - **STORE1**: `i2c_store_data`=1, `i2c_data`=value.
  - **STORE_END**: `i2c_store_data`=0 for 1 cycle.
  - **WAIT_RDY2**: wait `i2c_device_rdy`=1.
  - **SEND**: `i2c_send_data`=1 for exactly 1 cycle.
  - **WAIT_BUSY**: wait `i2c_device_rdy`=0.
  - **WAIT_DONE**: wait `i2c_device_rdy`=1, then sample `i2c_error`.
    - `i2c_error`=0 → NEXT.
    - `i2c_error`=1 → retry handling (see Configuration).
  - **NEXT**: `rom_addr`+1 → ROM_WAIT.
  - **DELAY**: count `value` × (MAIN_CLOCK_FREQUENCY/1000) cycles → NEXT.
  - **DONE**: `cfg_done`←1, `busy`←0 → IDLE.
  - **FAIL**: `cfg_error`←1, `err_index`←`rom_addr`, `busy`←0 → IDLE.
- Timeout: a shared cycle counter clears on entry to each of WAIT_RDY1, WAIT_RDY2, WAIT_BUSY and WAIT_DONE. Reaching XFER_TIMEOUT_CYCLES → FAIL. Retries do not apply to timeouts.
- Table wrap-around: if `rom_addr` reaches all-ones without an end marker, that entry is processed, then → DONE.
- `start` while `busy` is ignored.

## Timing
- `i2c_store_data` is high for exactly 2 consecutive cycles, reg_addr then value, followed by at least 1 low cycle before `i2c_send_data`.
- `i2c_data` is stable during both store cycles. It holds its value otherwise.
- The table ROM is read with 1-cycle latency. `rom_data` is captured in DECODE only.
- Minimum per-write overhead outside the I2C transfer: 8 cycles.
- A delay entry of N ms lasts N×27000 +3 cycles (at the default MAIN_CLOCK_FREQUENCY) from DECODE to the next DECODE.
- Reset mid-operation, on a `rst_n`=0 sample: all outputs drop to 0 on the next edge and the FSM returns to IDLE. A pending `start` is cleared.

## Configuration
- `CAMERA_CFG_RETRY_EN` defined:
  - On a NACK, a per-entry retry counter increments. If it is below MAX_RETRIES → WAIT_RDY1, re-storing both bytes.
  - Otherwise → FAIL.
  - The counter clears on NEXT.
- Macro undefined:
  - Any NACK → FAIL immediately.
  - The retry counter is not instantiated.

## Test plan
- Table `{12 80}`, `{FF 01}`, `{11 01}`, `FFFF`, with the I2C model ACKing everything → writes 0x12=0x80 then 0x11=0x01. The two writes are separated by ≥27000 cycles. Then `cfg_done`=1, `busy`=0.
- Store framing → exactly 2 `i2c_store_data` cycles carrying 0x12 then 0x80, and one 1-cycle `i2c_send_data` pulse per entry.
- With retry enabled, the model NACKs entry 1 twice → 3 sends of entry 1, then completion with `cfg_done`=1.
- With retry enabled, the model always NACKs entry 2 → 4 sends, then `cfg_error`=1, `err_index`=2. With retry disabled → 1 send, then FAIL.
- `i2c_device_rdy` held low after SEND → FAIL after 2_700_000 cycles with `cfg_error`=1.
- `start` before `i2c_init_done`, then `rst_n` pulsed low mid-transfer → sequence starts only after `init_done`; after reset, all outputs are 0 and the FSM is in IDLE.
